dmem_line_ctrl: RTL

Line-granular backing-memory controller that sits directly downstream of the data cache. It accepts one 256-bit line read or write per request over the cache's enable/write/ack handshake and models a fixed multi-cycle main-memory latency. It stores 512 lines (16 KB) and returns a single-cycle ack pulse on completion. The block replaces the bare behavioural memory with a latched-request, latency-counted FSM that the cache miss path can rely on cycle-exactly.

---
 rtl/dmem_line_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/dmem_line_ctrl.sv
// Line-granular backing memory for the data cache: one 256-bit line read or write
// per enable/write/ack handshake, completed a fixed LATENCY cycles after acceptance.
module dmem_line_ctrl #(
    parameter int LATENCY = 10,
    parameter int LINES   = 512,
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [IDX_W-1:0]  req_idx;
    logic              req_write;
    logic [DATA_W-1:0] req_data;

    logic [DATA_W-1:0] mem [LINES];

    // Byte offset within the line and address bits above the array wrap away.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

    // The FSM spends one cycle in ACK before the registered ack_o appears, so the
    // pulse lands on edge t0+LATENCY and the IDLE cycle that follows overlaps it,
    // which gives the LATENCY+1 minimum spacing between acceptances.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            req_idx   <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
            ack_o     <= 1'b0;
            busy_o    <= 1'b0;
            data_o    <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every read in this
            // block sees the pre-edge value, independent of statement order.
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        req_idx   <= addr_i[5 +: IDX_W];
                        req_write <= write_i;
                        req_data  <= data_i;
                        cnt       <= '0;
                        state     <= WAIT;
                        busy_o    <= 1'b1;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(LATENCY - 2)) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    // Read data and write commit coincide with the ack edge.
                    state <= IDLE;
                    ack_o <= 1'b1;
                    if (!req_write) begin
                        data_o <= mem[req_idx];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM and survives rst_i; a pending
    // write is still discarded because the commit is gated by the reset FSM state.
    always_ff @(posedge clk_i) begin
        if (state == ACK && req_write) begin
            mem[req_idx] <= req_data;
        end
    end

endmodule
